// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the 6502 bus: a 4-byte register window,
// an 8-deep byte FIFO and a start/data/stop serialiser with a programmable bit period.
module bus_uart_tx #(
    parameter logic [15:0] BASE       = 16'hFF00,
    parameter logic [15:0] DIV_RESET  = 16'd217,
    parameter int          DEPTH_LOG2 = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  data_in,
    input  logic        wren,
    output logic        sel,
    output logic [7:0]  data_out,
    output logic        tx,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // Register window and write qualification
    logic [15:0]           addr_hist_reg;
    logic                  wren_hist_reg;
    logic                  wr_repeat;
    logic                  wr_fire;
    logic                  wr_data;
    logic                  wr_status;
    logic                  wr_div_lo;
    logic                  wr_div_hi;

    // Control/status state
    logic [15:0]           div_reg;
    logic                  ie_reg;
    logic                  ovf_reg;
    logic                  irq_reg;

    // FIFO
    logic [7:0]            mem [0:DEPTH-1];
    logic [DEPTH_LOG2:0]   wr_ptr_reg;
    logic [DEPTH_LOG2:0]   rd_ptr_reg;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push_ok;
    logic                  ovf_set;
    logic                  fsm_pop;

    // Serialiser
    tx_state_t             state_reg;
    logic [15:0]           cnt_reg;
    logic [15:0]           bit_div_reg;
    logic [15:0]           div_eff;
    logic [7:0]            shift_reg;
    logic [2:0]            bit_idx_reg;
    logic                  tx_reg;
    logic                  busy;
    logic [7:0]            status_byte;

    assign sel = (address[15:2] == BASE[15:2]);

    // A strobe held across several clocks at the same address is one write.
    assign wr_repeat = wren_hist_reg && (addr_hist_reg == address);
    assign wr_fire   = wren && sel && !wr_repeat;
    assign wr_data   = wr_fire && (address[1:0] == 2'd0);
    assign wr_status = wr_fire && (address[1:0] == 2'd1);
    assign wr_div_lo = wr_fire && (address[1:0] == 2'd2);
    assign wr_div_hi = wr_fire && (address[1:0] == 2'd3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wren_hist_reg <= 1'b0;
            addr_hist_reg <= 16'h0000;
        end else begin
            wren_hist_reg <= wren;
            addr_hist_reg <= address;
        end
    end

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                        (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);

    assign busy    = (state_reg != ST_IDLE);
    assign fsm_pop = !fifo_empty &&
                     ((state_reg == ST_IDLE) ||
                      ((state_reg == ST_STOP) && (cnt_reg == 16'd0)));

    // A push while full still lands if the head leaves in the same cycle.
    assign push_ok = wr_data && (!fifo_full || fsm_pop);
    assign ovf_set = wr_data && fifo_full && !fsm_pop;

    // Storage has no reset; the pointers alone define its contents. When full,
    // push and pop share an index and the pop reads the old byte (read-first).
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (fsm_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_reg <= DIV_RESET;
            ie_reg  <= 1'b0;
            ovf_reg <= 1'b0;
            irq_reg <= 1'b0;
        end else begin
            if (wr_div_lo) begin
                div_reg[7:0] <= data_in;
            end
            if (wr_div_hi) begin
                div_reg[15:8] <= data_in;
            end
            if (wr_status) begin
                ie_reg <= data_in[7];
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end else if (wr_status && data_in[3]) begin
                ovf_reg <= 1'b0;
            end
            irq_reg <= ie_reg && fifo_empty && !busy;
        end
    end

    assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;

    // Every state bit lasts bit_div clocks: load bit_div-1 on entry, leave at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 16'd0;
            bit_div_reg <= 16'd1;
            shift_reg   <= 8'h00;
            bit_idx_reg <= 3'd0;
            tx_reg      <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift_reg   <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
                        bit_div_reg <= div_eff;
                        cnt_reg     <= div_eff - 16'd1;
                        tx_reg      <= 1'b0;
                        state_reg   <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_reg != 16'd0) begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end else begin
                        cnt_reg     <= bit_div_reg - 16'd1;
                        tx_reg      <= shift_reg[0];
                        bit_idx_reg <= 3'd0;
                        state_reg   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_reg != 16'd0) begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end else if (bit_idx_reg == 3'd7) begin
                        cnt_reg   <= bit_div_reg - 16'd1;
                        tx_reg    <= 1'b1;
                        state_reg <= ST_STOP;
                    end else begin
                        cnt_reg     <= bit_div_reg - 16'd1;
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                        tx_reg      <= shift_reg[1];
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_reg != 16'd0) begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next frame without an idle bit.
                        shift_reg   <= mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
                        bit_div_reg <= div_eff;
                        cnt_reg     <= div_eff - 16'd1;
                        tx_reg      <= 1'b0;
                        state_reg   <= ST_START;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

    assign status_byte = {ie_reg, 3'b000, ovf_reg, busy, fifo_empty, fifo_full};

    always_comb begin
        data_out = 8'h00;
        if (sel) begin
            case (address[1:0])
                2'd1:    data_out = status_byte;
                2'd2:    data_out = div_reg[7:0];
                2'd3:    data_out = div_reg[15:8];
                default: data_out = 8'h00;
            endcase
        end
    end

    assign tx  = tx_reg;
    assign irq = irq_reg;

endmodule
